// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one 128-bit block memory port between the icache (read) and dcache (read/write-back).
// Latency: request to ack is 2 cycles plus the number of cycles memory holds MAIN_MEM_BUSY_WAIT high (minimum 3).
// Backpressure: requesters stall on x_BUSY_WAIT until their ack cycle; the arbiter waits on MAIN_MEM_BUSY_WAIT.
module cache_mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READ_DATA,
  output logic              I_BUSY_WAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITE_DATA,
  output logic [DATA_W-1:0] D_READ_DATA,
  output logic              D_BUSY_WAIT,
  output logic              MAIN_MEM_READ,
  output logic              MAIN_MEM_WRITE,
  output logic [ADDR_W-1:0] MAIN_MEM_ADDRESS,
  output logic [DATA_W-1:0] MAIN_MEM_WRITE_DATA,
  input  logic [DATA_W-1:0] MAIN_MEM_READ_DATA,
  input  logic              MAIN_MEM_BUSY_WAIT
);

  typedef enum logic [2:0] {IDLE, I_ACCESS, I_WAIT, D_ACCESS, D_WAIT} state_t;

  state_t            r_state;
  logic              r_last_d;     // 1 when the dcache received the most recent grant
  logic              r_ack_i;
  logic              r_ack_d;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_req_i;
  logic w_req_d;
  logic w_elig_i;
  logic w_elig_d;
  logic w_grant_i;
  logic w_grant_d;

  // Raw requests, masking of a requester still in its ack cycle, and the round-robin pick.
  always_comb begin
    w_req_i   = I_READ;
    w_req_d   = D_READ | D_WRITE;
    w_elig_i  = w_req_i & ~r_ack_i;
    w_elig_d  = w_req_d & ~r_ack_d;
    w_grant_i = w_elig_i & (~w_elig_d | r_last_d);
    w_grant_d = w_elig_d & (~w_elig_i | ~r_last_d);
  end

  // Arbitration FSM: latch the granted request, sequence it through memory, pulse the ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b1;
      r_ack_i     <= 1'b0;
      r_ack_d     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_ack_i <= 1'b0;
      r_ack_d <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state     <= I_ACCESS;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= I_ADDRESS;
            r_last_d    <= 1'b0;
          end else if (w_grant_d) begin
            // A write-back wins over a simultaneous read strobe
            r_state     <= D_ACCESS;
            r_mem_read  <= ~D_WRITE;
            r_mem_write <= D_WRITE;
            r_mem_addr  <= D_ADDRESS;
            r_mem_wdata <= D_WRITE_DATA;
            r_last_d    <= 1'b1;
          end
        end
        // Memory only raises busywait after it samples the strobe, so skip one cycle before watching it
        I_ACCESS: r_state <= I_WAIT;
        I_WAIT: begin
          if (!MAIN_MEM_BUSY_WAIT) begin
            r_mem_read <= 1'b0;
            r_i_rdata  <= MAIN_MEM_READ_DATA;
            r_ack_i    <= 1'b1;
            r_state    <= IDLE;
          end
        end
        D_ACCESS: r_state <= D_WAIT;
        D_WAIT: begin
          if (!MAIN_MEM_BUSY_WAIT) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_mem_read) begin
              r_d_rdata <= MAIN_MEM_READ_DATA;
            end
            r_ack_d <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MAIN_MEM_READ       = r_mem_read;
  assign MAIN_MEM_WRITE      = r_mem_write;
  assign MAIN_MEM_ADDRESS    = r_mem_addr;
  assign MAIN_MEM_WRITE_DATA = r_mem_wdata;
  assign I_READ_DATA         = r_i_rdata;
  assign D_READ_DATA         = r_d_rdata;
  // Stall drops only in the ack cycle, when the returned block is valid
  assign I_BUSY_WAIT         = w_req_i & ~r_ack_i;
  assign D_BUSY_WAIT         = w_req_d & ~r_ack_d;

endmodule
